// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: turns decoder target enables into a CPU ready pulse and registered read data,
// with per-target wait states, a flash handshake and a turnaround cycle; CPU_BUS_TIMEOUT_EN adds a flash timeout.
module cpu_bus_responder #(
  parameter int RAM_LATENCY    = 0,
  parameter int VDP_LATENCY    = 2,
  parameter int DSP_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_mem_valid,
  input  logic [3:0]  cpu_wstrb,
  input  logic        cpu_ram_en,
  input  logic        vdp_en,
  input  logic        status_en,
  input  logic        dsp_en,
  input  logic        flash_read_en,
  input  logic [31:0] ram_rdata,
  input  logic [15:0] vdp_rdata,
  input  logic [31:0] status_rdata,
  input  logic [15:0] dsp_rdata,
  input  logic [31:0] flash_rdata,
  input  logic        flash_ready,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_rdata,
  output logic        bus_error
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_TURN} state_e;
  localparam logic [2:0] T_RAM = 3'd0, T_VDP = 3'd1, T_STS = 3'd2, T_DSP = 3'd3, T_FLASH = 3'd4;
  state_e      state_q, state_d;
  logic [2:0]  tgt_q, tgt_d;
  logic        wr_q, wr_d, rdy_q, rdy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d, sel_data;
  logic        flash_rd, done, expire, any_en;
  assign any_en   = cpu_ram_en | vdp_en | status_en | dsp_en | flash_read_en;
  assign flash_rd = tgt_q == T_FLASH && !wr_q;
  assign done     = flash_rd ? flash_ready : cnt_q == 4'd0;
  assign sel_data = tgt_q == T_RAM ? ram_rdata :
                    tgt_q == T_VDP ? {16'h0, vdp_rdata} :
                    tgt_q == T_STS ? status_rdata :
                    tgt_q == T_DSP ? {16'h0, dsp_rdata} : flash_rdata;
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rdy_d   = 1'b0;
    case (state_q)
      S_IDLE: if (cpu_mem_valid && any_en) begin
        tgt_d   = cpu_ram_en ? T_RAM : vdp_en ? T_VDP : status_en ? T_STS : dsp_en ? T_DSP : T_FLASH;
        wr_d    = |cpu_wstrb;
        cnt_d   = cpu_ram_en ? 4'(RAM_LATENCY) : vdp_en ? 4'(VDP_LATENCY) :
                  (!status_en && dsp_en) ? 4'(DSP_LATENCY) : 4'd0;
        state_d = S_WAIT;
      end
      S_WAIT: if (!cpu_mem_valid) state_d = S_IDLE;
        else if (done || expire) begin
          rdata_d = wr_q ? 32'h0 : expire ? 32'hFFFF_FFFF : sel_data;
          rdy_d   = 1'b1;
          state_d = S_ACK;
        end else cnt_d = cnt_q - {3'd0, cnt_q != 4'd0};
      S_ACK:   state_d = S_TURN;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tgt_q   <= T_RAM;
      wr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
    end
  end
`ifdef CPU_BUS_TIMEOUT_EN
  // Reloaded every idle cycle so each flash read gets a full TIMEOUT_CYCLES window.
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  assign expire = flash_rd && !flash_ready && tmo_q == 8'd0;
  assign tmo_d  = state_q == S_WAIT ? tmo_q - {7'd0, tmo_q != 8'd0} : 8'(TIMEOUT_CYCLES - 1);
  assign err_d  = state_q == S_WAIT && cpu_mem_valid && expire;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign bus_error = err_q;
`else
  assign expire    = 1'b0;
  assign bus_error = 1'b0;
`endif
  assign cpu_mem_ready = rdy_q;
  assign cpu_rdata     = rdata_q;
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed and randomized transfers checked against a latency/data reference model.
module tb_cpu_bus_responder;
  localparam int RAM_LAT = 0, VDP_LAT = 2, DSP_LAT = 1, TMO = 12;
  localparam int NEVER = 100000;
  logic        clk = 1'b0, reset_n = 1'b0, cpu_mem_valid = 1'b0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_ram_en = 1'b0, vdp_en = 1'b0, status_en = 1'b0, dsp_en = 1'b0, flash_read_en = 1'b0;
  logic [31:0] ram_rdata = '0, status_rdata = '0, flash_rdata = '0;
  logic [15:0] vdp_rdata = '0, dsp_rdata = '0;
  logic        flash_ready = 1'b0;
  logic        cpu_mem_ready, bus_error;
  logic [31:0] cpu_rdata;
  logic [31:0] rd_model = '0;
  int          errors = 0, checks = 0;

  cpu_bus_responder #(.RAM_LATENCY(RAM_LAT), .VDP_LATENCY(VDP_LAT), .DSP_LATENCY(DSP_LAT),
                      .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_mem_valid(cpu_mem_valid), .cpu_wstrb(cpu_wstrb),
    .cpu_ram_en(cpu_ram_en), .vdp_en(vdp_en), .status_en(status_en), .dsp_en(dsp_en),
    .flash_read_en(flash_read_en), .ram_rdata(ram_rdata), .vdp_rdata(vdp_rdata),
    .status_rdata(status_rdata), .dsp_rdata(dsp_rdata), .flash_rdata(flash_rdata),
    .flash_ready(flash_ready), .cpu_mem_ready(cpu_mem_ready), .cpu_rdata(cpu_rdata),
    .bus_error(bus_error));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    cpu_mem_valid = 1'b0;
    {cpu_ram_en, vdp_en, status_en, dsp_en, flash_read_en} = '0;
    cpu_wstrb   = '0;
    flash_ready = 1'b0;
  endtask

  // en = {flash, dsp, status, vdp, ram}; k = cycle after T0 in which flash_ready rises
  task automatic xfer(input logic [4:0] en, input logic [3:0] ws, input logic [31:0] d_ram,
                      input logic [15:0] d_vdp, input logic [31:0] d_sts, input logic [15:0] d_dsp,
                      input logic [31:0] d_flash, input int k, input int budget);
    int lat, got;
    logic [31:0] ed;
    logic ee;
    ee = 1'b0;
    if (en[0]) begin lat = RAM_LAT + 1; ed = d_ram; end
    else if (en[1]) begin lat = VDP_LAT + 1; ed = {16'h0, d_vdp}; end
    else if (en[2]) begin lat = 1; ed = d_sts; end
    else if (en[3]) begin lat = DSP_LAT + 1; ed = {16'h0, d_dsp}; end
    else if (|ws) begin lat = 1; ed = '0; end
    else begin
      lat = k + 1;
      ed  = d_flash;
`ifdef CPU_BUS_TIMEOUT_EN
      if (k + 1 > TMO) begin lat = TMO; ed = 32'hFFFF_FFFF; ee = 1'b1; end
`endif
    end
    if (|ws) ed = '0;
    if (lat >= budget) lat = -1;
    @(negedge clk);
    cpu_mem_valid = 1'b1;
    {flash_read_en, dsp_en, status_en, vdp_en, cpu_ram_en} = en;
    cpu_wstrb = ws;
    ram_rdata = d_ram; vdp_rdata = d_vdp; status_rdata = d_sts; dsp_rdata = d_dsp;
    flash_rdata = $urandom;
    flash_ready = 1'b0;
    got = -1;
    @(posedge clk); #1;
    for (int n = 0; n < budget; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (cpu_mem_ready) begin got = n; break; end
      if (n == k) begin flash_ready = 1'b1; flash_rdata = d_flash; end
    end
    check("ready_latency", got, lat);
    if (lat >= 0 && got >= 0) begin
      check("rdata", cpu_rdata, ed);
      check("bus_error", {31'h0, bus_error}, {31'h0, ee});
      rd_model = ed;
    end else check("rdata_held_no_ack", cpu_rdata, rd_model);
    idle_bus();
    repeat (2) begin
      @(posedge clk); #1;
      check("ready_one_cycle", {31'h0, cpu_mem_ready}, 32'h0);
      check("error_one_cycle", {31'h0, bus_error}, 32'h0);
    end
    check("rdata_hold", cpu_rdata, rd_model);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'h0, cpu_mem_ready}, 32'h0);
    check("reset_rdata", cpu_rdata, 32'h0);
    check("reset_error", {31'h0, bus_error}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    xfer(5'b00001, 4'h0, 32'h1234_5678, 16'h0, 32'h0, 16'h0, 32'h0, NEVER, 40);
    xfer(5'b00010, 4'h0, 32'h0, 16'hBEEF, 32'h0, 16'h0, 32'h0, NEVER, 40);
    xfer(5'b10000, 4'h0, 32'h0, 16'h0, 32'h0, 16'h0, 32'hCAFE_F00D, 7, 40);
    xfer(5'b10000, 4'hF, 32'h0, 16'h0, 32'h0, 16'h0, 32'hCAFE_F00D, 0, 40);
    xfer(5'b01000, 4'h0, 32'h0, 16'h0, 32'h0, 16'h7E57, 32'h0, NEVER, 40);
    xfer(5'b01111, 4'h0, 32'h0000_0A0A, 16'h1, 32'h2, 16'h3, 32'h4, NEVER, 40);
    // abort: VDP read with valid dropped in its second WAIT cycle
    @(negedge clk);
    cpu_mem_valid = 1'b1; vdp_en = 1'b1; vdp_rdata = 16'h1111;
    @(posedge clk); #1;
    check("abort_t0", {31'h0, cpu_mem_ready}, 32'h0);
    @(posedge clk); #1;
    check("abort_t1", {31'h0, cpu_mem_ready}, 32'h0);
    idle_bus();
    @(posedge clk); #1;
    check("abort_t2", {31'h0, cpu_mem_ready}, 32'h0);
    check("abort_rdata", cpu_rdata, rd_model);
    xfer(5'b00100, 4'h0, 32'h0, 16'h0, 32'hA5A5_0001, 16'h0, 32'h0, NEVER, 40);
    // reset pulsed in the middle of a VDP wait
    @(negedge clk);
    cpu_mem_valid = 1'b1; vdp_en = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midreset_ready", {31'h0, cpu_mem_ready}, 32'h0);
    check("midreset_rdata", cpu_rdata, 32'h0);
    rd_model = '0;
    @(negedge clk);
    idle_bus();
    reset_n = 1'b1;
    xfer(5'b00001, 4'h0, 32'h1234_5678, 16'h0, 32'h0, 16'h0, 32'h0, NEVER, 40);
    xfer(5'b10000, 4'h0, 32'h0, 16'h0, 32'h0, 16'h0, 32'h0, NEVER, 300);
    xfer(5'b10000, 4'h0, 32'h0, 16'h0, 32'h0, 16'h0, 32'h600D_DA7A, TMO - 1, 300);
    for (int i = 0; i < 60; i++) begin
      logic [4:0] en;
      logic [3:0] ws;
      en = 5'(1 << $urandom_range(4, 0)) | (($urandom_range(3, 0) == 0) ? 5'($urandom) : 5'd0);
      ws = ($urandom_range(2, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'd0;
      xfer(en, ws, $urandom, 16'($urandom), $urandom, 16'($urandom), $urandom,
           int'($urandom_range(14, 0)), 40);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
